match_controller: RTL and testbench
===================================

// Module: match_controller
//
// PURPOSE
//   Match-level sequencer for pong. It sits between game_logic and the top level.
//   It steps the game through idle, serve, rally, point and game-over phases,
//   counting frames on the display's new_frame pulse.
//   It keeps both scores and gates ball motion via play_en_o / ball_rst_o.
//   It consumes miss events from game_logic and the start/pause keys.
//
// PARAMETERS
//   WIN_SCORE     11  points needed to win the match (1..15)
//   SERVE_FRAMES  60  frames the ball is held before launch
//   POINT_FRAMES  90  frames of pause after a point is scored
//   START_KEY     0   index into keys_i used as the start button
//   PAUSE_KEY     1   index into keys_i used as the pause button
//
// PORTS
//   clk_i          in   1          system clock
//   rst_i          in   1          synchronous, active-high reset
//   keys_i         in   KEYS_W     raw key levels; these are already synchronised to clk_i
//   new_frame_i    in   1          one-cycle pulse at the start of each frame
//   miss_left_i    in   1          one-cycle pulse: ball passed the player's (left) edge
//   miss_right_i   in   1          one-cycle pulse: ball passed the enemy's (right) edge
//   play_en_o      out  1          ball/paddle motion enable
//   ball_rst_o     out  1          hold the ball at the centre
//   serve_dir_o    out  1          launch direction: 0 = towards the left, 1 = towards the right
//   player_score_o out  SCORE_W    player score
//   enemy_score_o  out  SCORE_W    enemy score
//   game_over_o    out  1          match finished
//   winner_o       out  1          0 = player, 1 = enemy; valid while game_over_o
//
// BEHAVIOUR
// - Reset values:
//   - state IDLE, both scores 0, frame counter 0.
//   - play_en_o=0, ball_rst_o=1, serve_dir_o=1, game_over_o=0, winner_o=0.
// - Key edges:
//   - Start and pause act on rising edges only: the previous key levels are registered and compared.
//   - A held key never re-triggers.
//   - After reset the previous-level register is 1, so a key held through reset does not fire.
// - Frame counter:
//   - It is reloaded to 0 on every state entry.
//   - It increments only on cycles where new_frame_i=1.
//   - A new_frame_i pulse on the entry cycle itself is not counted.
// - Outputs by state:
//   - IDLE:      play_en=0, ball_rst=1.
//   - SERVE:     play_en=0, ball_rst=1.
//   - PLAY:      play_en=1, ball_rst=0.
//   - POINT:     play_en=0, ball_rst=1.
//   - GAME_OVER: play_en=0, ball_rst=1, game_over_o=1.
//   - All outputs are registered and change 1 cycle after the transition condition.
// - Transitions:
//   - IDLE --start edge--> SERVE. Both scores clear to 0 in the same cycle.
//   - SERVE --(SERVE_FRAMES counted frames)--> PLAY.
//   - PLAY --miss_left_i--> POINT: enemy_score+1, serve_dir_o=0 (serve towards the loser).
//   - PLAY --miss_right_i--> POINT: player_score+1, serve_dir_o=1.
//   - PLAY, with miss_left_i and miss_right_i in the same cycle --> SERVE. No score change; serve_dir_o unchanged.
//   - POINT --(POINT_FRAMES counted frames)--> GAME_OVER if either score == WIN_SCORE, else SERVE.
//   - GAME_OVER --start edge--> SERVE. Scores clear and serve_dir_o=1.
//   - On entry to GAME_OVER, winner_o = (enemy_score == WIN_SCORE).
// - Miss pulses are ignored in every state except PLAY.
// - Scores saturate at WIN_SCORE and never wrap.
// - SCORE_W = $clog2(WIN_SCORE+1).
// - rst_i at any point, including mid-rally or mid-count, returns everything to the reset values on the next edge.
//
// CONFIGURATION
// - MATCH_PAUSE_EN defined:
//   - Adds state PAUSED.
//   - PLAY --pause edge--> PAUSED, with play_en=0 and ball_rst=0 so the ball freezes in place.
//   - PAUSED --pause edge--> PLAY.
//   - Miss pulses are ignored in PAUSED.
//   - A start edge in PAUSED --> IDLE (abandons the match).
// - MATCH_PAUSE_EN undefined:
//   - PAUSE_KEY is ignored and PAUSED does not exist in the enum.
//
// STRUCTURE
// - The shared pong_pkg holds:
//   - KEYS_W;
//   - match_state_t enum {IDLE, SERVE, PLAY, POINT, GAME_OVER[, PAUSED]};
//   - side_e {SIDE_PLAYER=0, SIDE_ENEMY=1}.
// - Sub-module key_edge_det, parameterised on width, produces the rising-edge pulses for both keys.
// - The FSM, frame counter and score registers stay in this module.
//
// TESTING
// - Reset, then hold the start key high across the reset release -> no start edge is seen and the FSM stays in IDLE.
// - Start edge, then 60 new_frame pulses -> play_en_o rises 1 cycle after the 60th pulse; ball_rst_o falls.
// - In PLAY, a single miss_right_i pulse -> player_score_o=1, serve_dir_o=1; the FSM returns to SERVE after 90 frames.
// - With WIN_SCORE=3, three miss_left_i points -> enemy_score_o=3, game_over_o=1, winner_o=1.
//   Then a start edge -> scores 0 and the FSM is in SERVE.
// - miss_left_i and miss_right_i in the same cycle during PLAY -> scores unchanged, the FSM goes to SERVE, serve_dir_o unchanged.
// - MATCH_PAUSE_EN: pause edge in PLAY -> play_en_o=0, ball_rst_o=0, and a miss pulse is ignored.
//   A second pause edge -> PLAY resumes.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions.
//   KEYS_W        width of the raw key vector
//   match_state_t match-level FSM states; PAUSED exists only when the
//                 MATCH_PAUSE_EN macro is defined
//   side_e        which side of the court a point or serve refers to
package pong_pkg;

    localparam int KEYS_W = 4;

`ifdef MATCH_PAUSE_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4,
        PAUSED    = 3'd5
    } match_state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } match_state_t;
`endif

    typedef enum logic {
        SIDE_PLAYER = 1'b0,
        SIDE_ENEMY  = 1'b1
    } side_e;

endpackage

// File: rtl/match_controller_if.sv
// Bus between the match controller and the rest of the game.
//   master : drives keys_i, new_frame_i, miss_left_i, miss_right_i and
//            observes the match outputs (game_logic / top level / bench)
//   slave  : the match controller itself
// SCORE_W must equal $clog2(WIN_SCORE+1) of the attached controller.
interface match_controller_if #(
    parameter int SCORE_W = 4
) ();
    import pong_pkg::*;

    logic [KEYS_W-1:0]  keys_i;
    logic               new_frame_i;
    logic               miss_left_i;
    logic               miss_right_i;
    logic               play_en_o;
    logic               ball_rst_o;
    logic               serve_dir_o;
    logic [SCORE_W-1:0] player_score_o;
    logic [SCORE_W-1:0] enemy_score_o;
    logic               game_over_o;
    logic               winner_o;

    modport master (
        output keys_i, new_frame_i, miss_left_i, miss_right_i,
        input  play_en_o, ball_rst_o, serve_dir_o,
               player_score_o, enemy_score_o, game_over_o, winner_o
    );

    modport slave (
        input  keys_i, new_frame_i, miss_left_i, miss_right_i,
        output play_en_o, ball_rst_o, serve_dir_o,
               player_score_o, enemy_score_o, game_over_o, winner_o
    );
endinterface

// File: rtl/match_controller_key_edge_det.sv
// key_edge_det: rising-edge detector for a vector of synchronised key levels.
//   clk_i, rst_i : clock and synchronous active-high reset
//   i_level      : current key levels
//   o_rise       : one-cycle pulse per bit on a 0->1 transition
// The previous-level register resets to all ones so that a key already held
// when reset is released does not produce an edge.
module key_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_prev <= '1;
        else       r_prev <= i_level;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
            assign o_rise[gi] = i_level[gi] & ~r_prev[gi];
        end
    endgenerate
endmodule

// File: rtl/match_controller.sv
// match_controller: match-level sequencer for pong.
// Steps the game through IDLE -> SERVE -> PLAY -> POINT -> (SERVE | GAME_OVER),
// counts frames on new_frame_i, keeps both scores and gates ball motion.
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus (slave)  : keys_i, new_frame_i, miss_left_i, miss_right_i in;
//                  play_en_o, ball_rst_o, serve_dir_o, player_score_o,
//                  enemy_score_o, game_over_o, winner_o out
// Build option: define MATCH_PAUSE_EN to add the PAUSED state driven by the
// pause key; without it the pause key is ignored.
module match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int START_KEY    = 0,
    parameter int PAUSE_KEY    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    match_controller_if.slave  bus
);
    localparam int SCORE_W    = $clog2(WIN_SCORE + 1);
    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    // Catch mis-wired key indices at elaboration.
    generate
        if (START_KEY >= KEYS_W || PAUSE_KEY >= KEYS_W || START_KEY == PAUSE_KEY) begin : g_bad_key_index
            $error("match_controller: START_KEY/PAUSE_KEY must be distinct and below KEYS_W");
        end
    endgenerate

    // Key edges: bit 0 = start, bit 1 = pause (pause only when enabled).
`ifdef MATCH_PAUSE_EN
    localparam int EDGE_W = 2;
    logic [EDGE_W-1:0] w_key_level;
    logic [EDGE_W-1:0] w_key_rise;
    logic              w_pause_rise;
    assign w_key_level  = {bus.keys_i[PAUSE_KEY], bus.keys_i[START_KEY]};
    assign w_pause_rise = w_key_rise[1];
`else
    localparam int EDGE_W = 1;
    logic [EDGE_W-1:0] w_key_level;
    logic [EDGE_W-1:0] w_key_rise;
    assign w_key_level = bus.keys_i[START_KEY];
`endif
    logic w_start_rise;
    assign w_start_rise = w_key_rise[0];

    key_edge_det #(.WIDTH(EDGE_W)) u_key_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_level (w_key_level),
        .o_rise  (w_key_rise)
    );

    match_state_t       r_state, w_state_next;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [SCORE_W-1:0] r_player_score, w_player_next;
    logic [SCORE_W-1:0] r_enemy_score, w_enemy_next;
    logic               r_serve_dir, w_serve_dir_next;
    logic               r_winner, w_winner_next;
    logic               r_play_en, r_ball_rst, r_game_over;

    always_comb begin
        w_state_next     = r_state;
        w_player_next    = r_player_score;
        w_enemy_next     = r_enemy_score;
        w_serve_dir_next = r_serve_dir;
        w_winner_next    = r_winner;
        unique case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_state_next  = SERVE;
                    w_player_next = '0;
                    w_enemy_next  = '0;
                end
            end
            SERVE: begin
                if (bus.new_frame_i && r_frame_cnt == SERVE_LAST) w_state_next = PLAY;
            end
            PLAY: begin
                // Simultaneous misses are a void rally: re-serve, no score.
                if (bus.miss_left_i && bus.miss_right_i) begin
                    w_state_next = SERVE;
                end else if (bus.miss_left_i) begin
                    w_state_next     = POINT;
                    w_enemy_next     = (r_enemy_score == WIN) ? r_enemy_score : r_enemy_score + 1'b1;
                    w_serve_dir_next = SIDE_PLAYER;
                end else if (bus.miss_right_i) begin
                    w_state_next     = POINT;
                    w_player_next    = (r_player_score == WIN) ? r_player_score : r_player_score + 1'b1;
                    w_serve_dir_next = SIDE_ENEMY;
                end
`ifdef MATCH_PAUSE_EN
                else if (w_pause_rise) begin
                    w_state_next = PAUSED;
                end
`endif
            end
            POINT: begin
                if (bus.new_frame_i && r_frame_cnt == POINT_LAST) begin
                    if (r_player_score == WIN || r_enemy_score == WIN) begin
                        w_state_next  = GAME_OVER;
                        w_winner_next = (r_enemy_score == WIN);
                    end else begin
                        w_state_next = SERVE;
                    end
                end
            end
            GAME_OVER: begin
                if (w_start_rise) begin
                    w_state_next     = SERVE;
                    w_player_next    = '0;
                    w_enemy_next     = '0;
                    w_serve_dir_next = SIDE_ENEMY;
                end
            end
`ifdef MATCH_PAUSE_EN
            PAUSED: begin
                if (w_start_rise)      w_state_next = IDLE;
                else if (w_pause_rise) w_state_next = PLAY;
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_frame_cnt    <= '0;
            r_player_score <= '0;
            r_enemy_score  <= '0;
            r_serve_dir    <= 1'b1;
            r_winner       <= 1'b0;
            r_play_en      <= 1'b0;
            r_ball_rst     <= 1'b1;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_player_score <= w_player_next;
            r_enemy_score  <= w_enemy_next;
            r_serve_dir    <= w_serve_dir_next;
            r_winner       <= w_winner_next;
            // Reload on the transition edge so a pulse coinciding with the
            // entry is not counted. Wrap in non-counting states is harmless.
            if (w_state_next != r_state) r_frame_cnt <= '0;
            else if (bus.new_frame_i)    r_frame_cnt <= r_frame_cnt + 1'b1;
            // Outputs decoded from the next state so they land with the state.
            r_play_en   <= (w_state_next == PLAY);
            r_game_over <= (w_state_next == GAME_OVER);
`ifdef MATCH_PAUSE_EN
            r_ball_rst  <= !(w_state_next == PLAY || w_state_next == PAUSED);
`else
            r_ball_rst  <= (w_state_next != PLAY);
`endif
        end
    end

    assign bus.play_en_o      = r_play_en;
    assign bus.ball_rst_o     = r_ball_rst;
    assign bus.serve_dir_o    = r_serve_dir;
    assign bus.player_score_o = r_player_score;
    assign bus.enemy_score_o  = r_enemy_score;
    assign bus.game_over_o    = r_game_over;
    assign bus.winner_o       = r_winner;
endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller with WIN_SCORE=3, SERVE_FRAMES=60, POINT_FRAMES=90.
// A table of {inputs, cycles, expected outputs} drives the main match flow;
// hand-written sequences cover reset mid-count, spaced frame pulses with a
// pulse on the entry cycle, and the pause key (MATCH_PAUSE_EN aware).
module tb_match_controller;
    import pong_pkg::*;

    localparam int WIN   = 3;
    localparam int SW    = $clog2(WIN + 1);
    localparam int OUT_W = 3 + 2 * SW + 2;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    match_controller_if #(.SCORE_W(SW)) bus ();

    match_controller #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (60),
        .POINT_FRAMES (90),
        .START_KEY    (0),
        .PAUSE_KEY    (1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string             name;
        logic [KEYS_W-1:0] keys;
        bit                nf, ml, mr;
        int                cycles;
        bit                pe, br, sd;
        int                ps, es;
        bit                go, w;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string name, logic [KEYS_W-1:0] keys, bit nf, bit ml, bit mr,
                                int cycles, bit pe, bit br, bit sd, int ps, int es, bit go, bit w);
        vec_t v;
        v.name = name; v.keys = keys; v.nf = nf; v.ml = ml; v.mr = mr; v.cycles = cycles;
        v.pe = pe; v.br = br; v.sd = sd; v.ps = ps; v.es = es; v.go = go; v.w = w;
        return v;
    endfunction

    // Packed order: play_en, ball_rst, serve_dir, player, enemy, game_over, winner
    function automatic logic [OUT_W-1:0] pack_exp(bit pe, bit br, bit sd, int ps, int es, bit go, bit w);
        logic [SW-1:0] p;
        logic [SW-1:0] e;
        p = SW'(ps);
        e = SW'(es);
        return {pe, br, sd, p, e, go, w};
    endfunction

    // winner_o is only meaningful while game_over_o is high.
    function automatic logic [OUT_W-1:0] mask_for(bit go);
        logic [OUT_W-1:0] m;
        m = '1;
        if (!go) m[0] = 1'b0;
        return m;
    endfunction

    task automatic check(string name, logic [OUT_W-1:0] exp, logic [OUT_W-1:0] mask);
        logic [OUT_W-1:0] act;
        act = {bus.play_en_o, bus.ball_rst_o, bus.serve_dir_o, bus.player_score_o,
               bus.enemy_score_o, bus.game_over_o, bus.winner_o};
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            failures++;
            $display("FAIL %s: pe/br/sd/ps/es/go/w got %b required %b (mask %b)", name, act, exp, mask);
        end else begin
            $display("ok   %s: pe/br/sd/ps/es/go/w = %b", name, act);
        end
    endtask

    // Called at posedge+1; leaves the inputs applied for n edges and returns at posedge+1.
    task automatic step(logic [KEYS_W-1:0] keys, bit nf, bit ml, bit mr, int n);
        bus.keys_i       = keys;
        bus.new_frame_i  = nf;
        bus.miss_left_i  = ml;
        bus.miss_right_i = mr;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // keys: 1 = start, 2 = pause
        vq.push_back(mk("held_start_ignored",  1, 1, 0, 0, 70, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk("release_start",       0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk("start_edge",          1, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk("serve_59_key_held",   1, 1, 0, 0, 59, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk("serve_60th_frame",    0, 1, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk("play_frames",         0, 1, 0, 0, 10, 1, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk("miss_right_point",    0, 0, 0, 1,  1, 0, 1, 1, 1, 0, 0, 0));
        vq.push_back(mk("miss_in_point",       0, 0, 1, 0,  1, 0, 1, 1, 1, 0, 0, 0));
        vq.push_back(mk("point_89_frames",     0, 1, 0, 0, 89, 0, 1, 1, 1, 0, 0, 0));
        vq.push_back(mk("point_90th_frame",    0, 1, 0, 0,  1, 0, 1, 1, 1, 0, 0, 0));
        vq.push_back(mk("misses_in_serve",     0, 0, 1, 1,  1, 0, 1, 1, 1, 0, 0, 0));
        vq.push_back(mk("serve_to_play_1",     0, 1, 0, 0, 60, 1, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk("double_miss",         0, 0, 1, 1,  1, 0, 1, 1, 1, 0, 0, 0));
        vq.push_back(mk("serve_to_play_2",     0, 1, 0, 0, 60, 1, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk("miss_left_1",         0, 0, 1, 0,  1, 0, 1, 0, 1, 1, 0, 0));
        vq.push_back(mk("point_wait_1",        0, 1, 0, 0, 90, 0, 1, 0, 1, 1, 0, 0));
        vq.push_back(mk("serve_to_play_3",     0, 1, 0, 0, 60, 1, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk("double_miss_dir",     0, 0, 1, 1,  1, 0, 1, 0, 1, 1, 0, 0));
        vq.push_back(mk("serve_to_play_4",     0, 1, 0, 0, 60, 1, 0, 0, 1, 1, 0, 0));
        vq.push_back(mk("miss_left_2",         0, 0, 1, 0,  1, 0, 1, 0, 1, 2, 0, 0));
        vq.push_back(mk("point_wait_2",        0, 1, 0, 0, 90, 0, 1, 0, 1, 2, 0, 0));
        vq.push_back(mk("serve_to_play_5",     0, 1, 0, 0, 60, 1, 0, 0, 1, 2, 0, 0));
        vq.push_back(mk("start_in_play",       1, 0, 0, 0,  1, 1, 0, 0, 1, 2, 0, 0));
        vq.push_back(mk("miss_left_3",         0, 0, 1, 0,  1, 0, 1, 0, 1, 3, 0, 0));
        vq.push_back(mk("point_89_final",      0, 1, 0, 0, 89, 0, 1, 0, 1, 3, 0, 0));
        vq.push_back(mk("game_over_entry",     0, 1, 0, 0,  1, 0, 1, 0, 1, 3, 1, 1));
        vq.push_back(mk("miss_in_game_over",   0, 0, 0, 1,  1, 0, 1, 0, 1, 3, 1, 1));
        vq.push_back(mk("frames_in_game_over", 0, 1, 0, 0,100, 0, 1, 0, 1, 3, 1, 1));
        vq.push_back(mk("restart_edge",        1, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk("restart_serve",       0, 1, 0, 0, 60, 1, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk("miss_right_mid",      0, 0, 0, 1,  1, 0, 1, 1, 1, 0, 0, 0));

        // Reset with the start key held through the release.
        rst              = 1'b1;
        bus.keys_i       = 1;
        bus.new_frame_i  = 1'b0;
        bus.miss_left_i  = 1'b0;
        bus.miss_right_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_values", pack_exp(0, 1, 1, 0, 0, 0, 0), '1);
        rst = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].keys, vq[i].nf, vq[i].ml, vq[i].mr, vq[i].cycles);
            check(vq[i].name,
                  pack_exp(vq[i].pe, vq[i].br, vq[i].sd, vq[i].ps, vq[i].es, vq[i].go, vq[i].w),
                  mask_for(vq[i].go));
        end

        // Reset in the middle of a POINT count; winner from the last game must clear.
        step(0, 1, 0, 0, 20);
        rst = 1'b1;
        step(0, 0, 0, 0, 1);
        check("reset_mid_count", pack_exp(0, 1, 1, 0, 0, 0, 0), '1);
        rst = 1'b0;
        step(0, 0, 0, 0, 1);

        // Start edge coinciding with a frame pulse, then pulses every third cycle.
        step(1, 1, 0, 0, 1);
        check("serve_entry_pulse", pack_exp(0, 1, 1, 0, 0, 0, 0), '1);
        for (int k = 0; k < 59; k++) begin
            step(0, 1, 0, 0, 1);
            step(0, 0, 0, 0, 2);
        end
        check("serve_59_spaced", pack_exp(0, 1, 1, 0, 0, 0, 0), '1);
        step(0, 1, 0, 0, 1);
        check("serve_60_spaced", pack_exp(1, 0, 1, 0, 0, 0, 0), '1);
        step(0, 0, 0, 0, 1);

`ifdef MATCH_PAUSE_EN
        step(2, 0, 0, 0, 1);
        check("pause_edge", pack_exp(0, 0, 1, 0, 0, 0, 0), '1);
        step(0, 0, 1, 0, 1);
        check("miss_in_pause", pack_exp(0, 0, 1, 0, 0, 0, 0), '1);
        step(2, 0, 0, 0, 1);
        check("resume_edge", pack_exp(1, 0, 1, 0, 0, 0, 0), '1);
        step(0, 0, 0, 0, 1);
        step(2, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("start_in_pause", pack_exp(0, 1, 1, 0, 0, 0, 0), '1);
        step(0, 1, 0, 0, 70);
        check("idle_after_abandon", pack_exp(0, 1, 1, 0, 0, 0, 0), '1);
`else
        step(2, 0, 0, 0, 1);
        check("pause_key_ignored", pack_exp(1, 0, 1, 0, 0, 0, 0), '1);
        step(0, 0, 1, 0, 1);
        check("miss_after_pause_key", pack_exp(0, 1, 0, 0, 1, 0, 0), '1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
